// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt controller: cause codes,
// mip bit positions, register-select encodings and the request FSM states.
package irq_ctrl_pkg;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    typedef enum logic [1:0] {
        WR_MSIP     = 2'd0,
        WR_MTIMECMP = 2'd1,
        WR_MTIME    = 2'd2,
        WR_NONE     = 2'd3
    } wr_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_WAIT_ACK,
        ST_SERVICE
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over the eligible interrupt set: MEI > MSI > MTI.
module irq_prio_enc
    import irq_ctrl_pkg::*;
(
    input  logic [63:0] eligible,
    output logic [3:0]  code,
    output logic        valid
);

    // Only the three architected interrupt bits take part in arbitration.
    logic unused_eligible_bits;
    assign unused_eligible_bits = ^{eligible[63:12], eligible[10:8], eligible[6:4], eligible[2:0]};

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        code  = '0;
        valid = 1'b0;
        if (eligible[MIP_MEIP]) begin
            code  = CAUSE_MEI;
            valid = 1'b1;
        end else if (eligible[MIP_MSIP]) begin
            code  = CAUSE_MSI;
            valid = 1'b1;
        end else if (eligible[MIP_MTIP]) begin
            code  = CAUSE_MTI;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mtime/mtimecmp timer, msip register,
// pending/enable gating and a request/acknowledge FSM toward the trap handler.
module irq_ctrl
    import irq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic [63:0] mie_mask,
    input  logic        mstatus_mie,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [63:0] wr_data,
    input  logic        trap_taken,
    input  logic        trap_done,
    output logic        irq_en,
    output logic [3:0]  irq_code,
    output logic [63:0] irq_val,
    output logic [63:0] mip_out,
    output logic [63:0] mtime_out
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic        mtip;
    logic [63:0] eligible;
    logic [3:0]  win_code;
    logic        win_valid;
    wr_sel_e     sel;
    irq_state_e  state, state_nxt;
    logic [3:0]  code_nxt;

    assign sel = wr_sel_e'(wr_sel);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime    <= '0;
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            // A write to mtime replaces this cycle's increment.
            if (wr_en && sel == WR_MTIME) mtime <= wr_data;
            else                          mtime <= mtime + 64'd1;
            if (wr_en && sel == WR_MTIMECMP) mtimecmp <= wr_data;
            if (wr_en && sel == WR_MSIP)     msip     <= wr_data[0];
        end
    end

    assign mtip = (mtime >= mtimecmp);

    always_comb begin
        mip_out           = '0;
        mip_out[MIP_MSIP] = msip;
        mip_out[MIP_MTIP] = mtip;
        mip_out[MIP_MEIP] = ext_irq;
    end

    assign eligible = mip_out & mie_mask & {64{mstatus_mie}};

    irq_prio_enc u_prio (
        .eligible (eligible),
        .code     (win_code),
        .valid    (win_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            irq_code <= '0;
        end else begin
            state    <= state_nxt;
            irq_code <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = irq_code;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_nxt = ST_FIRE;
                    code_nxt  = win_code;
                end
            end
            ST_FIRE:     state_nxt = ST_WAIT_ACK;
            // Without an acknowledge the request is dropped and re-arbitrated.
            ST_WAIT_ACK: state_nxt = trap_taken ? ST_SERVICE : ST_IDLE;
            ST_SERVICE:  if (trap_done) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    assign irq_en    = (state == ST_FIRE);
    assign irq_val   = '0;
    assign mtime_out = mtime;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized and directed bench for irq_ctrl: a cycle-level reference model
// predicts requests into a scoreboard that an independent monitor drains.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_irq;
    logic [63:0] mie_mask;
    logic        mstatus_mie;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [63:0] wr_data;
    logic        trap_taken;
    logic        trap_done;
    logic        irq_en;
    logic [3:0]  irq_code;
    logic [63:0] irq_val;
    logic [63:0] mip_out;
    logic [63:0] mtime_out;

    irq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ext_irq     (ext_irq),
        .mie_mask    (mie_mask),
        .mstatus_mie (mstatus_mie),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .trap_taken  (trap_taken),
        .trap_done   (trap_done),
        .irq_en      (irq_en),
        .irq_code    (irq_code),
        .irq_val     (irq_val),
        .mip_out     (mip_out),
        .mtime_out   (mtime_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] code;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    bit   done     = 1'b0;

    // Reference state: values the DUT holds after the most recent edge.
    logic [63:0] m_time, m_cmp;
    bit          m_msip, m_pulse, m_await, m_service;
    logic [3:0]  m_code;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_time    = '0;
        m_cmp     = '1;
        m_msip    = 1'b0;
        m_pulse   = 1'b0;
        m_await   = 1'b0;
        m_service = 1'b0;
        m_code    = '0;
    endtask

    function automatic logic [63:0] model_mip();
        logic [63:0] m;
        m     = '0;
        m[3]  = m_msip;
        m[7]  = (m_time >= m_cmp);
        m[11] = ext_irq;
        return m;
    endfunction

    function automatic logic [3:0] pick(input logic [63:0] elig, output bit any);
        int prio [3] = '{11, 3, 7};
        any  = 1'b0;
        pick = 4'd0;
        for (int i = 0; i < 3; i++) begin
            if (!any && elig[prio[i]]) begin
                any  = 1'b1;
                pick = 4'(prio[i]);
            end
        end
    endfunction

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_step();
        logic [63:0] elig;
        logic [3:0]  w;
        bit          any;
        cyc++;
        if (!rst) begin
            model_reset();
            return;
        end
        elig = mstatus_mie ? (model_mip() & mie_mask) : 64'd0;
        if (m_pulse) begin
            m_pulse = 1'b0;
            m_await = 1'b1;
        end else if (m_await) begin
            m_await   = 1'b0;
            m_service = trap_taken;
        end else if (m_service) begin
            if (trap_done) m_service = 1'b0;
        end else begin
            w = pick(elig, any);
            if (any) begin
                m_pulse = 1'b1;
                m_code  = w;
                sb.push_back('{cyc, w});
            end
        end
        if (wr_en && wr_sel == 2'd2) m_time = wr_data;
        else                         m_time = m_time + 64'd1;
        if (wr_en && wr_sel == 2'd1) m_cmp  = wr_data;
        if (wr_en && wr_sel == 2'd0) m_msip = wr_data[0];
    endtask

    task automatic advance();
        model_step();
        @(negedge clk);
        wr_en      = 1'b0;
        trap_taken = 1'b0;
        trap_done  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] s, input logic [63:0] d);
        wr_en   = 1'b1;
        wr_sel  = s;
        wr_data = d;
        advance();
    endtask

    task automatic reset_dut();
        ext_irq     = 1'b0;
        mie_mask    = '0;
        mstatus_mie = 1'b0;
        rst         = 1'b0;
        advance();
        rst = 1'b1;
    endtask

    task automatic wait_pulse(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (irq_en) begin
                found = 1'b1;
                break;
            end
            advance();
        end
    endtask

    // Monitor: compares every post-edge cycle and drains the scoreboard on each request.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (done) break;
            check("mtime_out", mtime_out, m_time);
            check("mip_out", mip_out, model_mip());
            check("irq_val", irq_val, 64'd0);
            check("irq_en", 64'(irq_en), 64'(m_pulse));
            check("irq_code", 64'(irq_code), 64'(m_code));
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missed_irq: got none, expected code %0d at cycle %0d", sb[0].code, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (irq_en) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_irq: got code %0d at cycle %0d, expected no request", irq_code, cyc);
                end else begin
                    e = sb.pop_front();
                    check("sb_cycle", 64'(cyc), 64'(e.cyc));
                    check("sb_code", 64'(irq_code), 64'(e.code));
                end
            end
        end
    end

    initial begin
        bit found;
        int cnt;
        rst = 1'b0; ext_irq = 1'b0; mie_mask = '0; mstatus_mie = 1'b0;
        wr_en = 1'b0; wr_sel = '0; wr_data = '0; trap_taken = 1'b0; trap_done = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_irq_en", 64'(irq_en), 64'd0);
        check("rst_irq_code", 64'(irq_code), 64'd0);
        check("rst_mtime", mtime_out, 64'd0);
        check("rst_mip", mip_out, 64'd0);
        check("rst_irq_val", irq_val, 64'd0);
        rst = 1'b1;

        // Timer interrupt at mtime == mtimecmp.
        reset_dut();
        mie_mask = 64'h80; mstatus_mie = 1'b1;
        wr(2'd2, 64'd10);
        check("tmr_mtime10", mtime_out, 64'd10);
        wr(2'd1, 64'd20);
        wait_pulse(40, found);
        check("tmr_found", 64'(found), 64'd1);
        check("tmr_mtime", mtime_out, 64'd21);
        check("tmr_code", 64'(irq_code), 64'd7);

        // Priority, service blocking and re-request latency.
        reset_dut();
        ext_irq = 1'b1; mie_mask = 64'h888;
        wr(2'd0, 64'd1);
        wr(2'd1, 64'd0);
        mstatus_mie = 1'b1;
        wait_pulse(10, found);
        check("prio_found", 64'(found), 64'd1);
        check("prio_code_mei", 64'(irq_code), 64'd11);
        advance();
        trap_taken = 1'b1;
        advance();
        ext_irq = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            trap_taken = 1'b1;
            advance();
            if (irq_en) cnt++;
        end
        check("service_quiet", 64'(cnt), 64'd0);
        trap_done = 1'b1;
        advance();
        check("rereq_idle", 64'(irq_en), 64'd0);
        advance();
        check("rereq_fire", 64'(irq_en), 64'd1);
        check("prio_code_msi", 64'(irq_code), 64'd3);

        // Unacknowledged request drops and refires.
        reset_dut();
        mie_mask = 64'h8;
        wr(2'd0, 64'd1);
        mstatus_mie = 1'b1;
        wait_pulse(10, found);
        check("noack_found", 64'(found), 64'd1);
        trap_done = 1'b1;
        advance();
        check("noack_wait", 64'(irq_en), 64'd0);
        advance();
        check("noack_idle", 64'(irq_en), 64'd0);
        advance();
        check("noack_refire", 64'(irq_en), 64'd1);
        check("noack_code", 64'(irq_code), 64'd3);

        // Global enable masks everything.
        reset_dut();
        mie_mask = 64'h8;
        wr(2'd0, 64'd1);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            advance();
            if (irq_en) cnt++;
        end
        check("mask_quiet", 64'(cnt), 64'd0);
        mstatus_mie = 1'b1;
        wait_pulse(10, found);
        check("mask_found", 64'(found), 64'd1);
        check("mask_code", 64'(irq_code), 64'd3);

        // mtime wrap and write-over-increment.
        reset_dut();
        wr(2'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        check("wrap_load", mtime_out, 64'hFFFF_FFFF_FFFF_FFFE);
        check("wrap_mtip_lo", 64'(mip_out[7]), 64'd0);
        advance();
        check("wrap_max", mtime_out, 64'hFFFF_FFFF_FFFF_FFFF);
        check("wrap_mtip_max", 64'(mip_out[7]), 64'd1);
        advance();
        check("wrap_zero", mtime_out, 64'd0);
        check("wrap_mtip_zero", 64'(mip_out[7]), 64'd0);
        wr(2'd2, 64'd5);
        check("write_prio", mtime_out, 64'd5);

        // Reset during FIRE kills the pulse at once.
        reset_dut();
        mie_mask = 64'h8;
        wr(2'd0, 64'd1);
        mstatus_mie = 1'b1;
        wait_pulse(10, found);
        rst = 1'b0;
        #1;
        check("rst_fire_irq_en", 64'(irq_en), 64'd0);
        advance();
        rst = 1'b1;

        // Reset during SERVICE.
        mie_mask = 64'h8;
        wr(2'd0, 64'd1);
        wait_pulse(10, found);
        advance();
        trap_taken = 1'b1;
        advance();
        rst = 1'b0;
        advance();
        check("rst_svc_irq_en", 64'(irq_en), 64'd0);
        check("rst_svc_code", 64'(irq_code), 64'd0);
        check("rst_svc_mip", mip_out, 64'd0);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            advance();
            if (irq_en) cnt++;
        end
        check("rst_svc_quiet", 64'(cnt), 64'd0);

        // Randomized traffic against the reference model.
        reset_dut();
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom % 250) != 0;
            ext_irq     = ($urandom % 4) == 0;
            mstatus_mie = ($urandom % 4) != 0;
            if (i % 16 == 0) mie_mask = {$urandom, $urandom};
            trap_taken  = $urandom % 2;
            trap_done   = ($urandom % 3) == 0;
            if ($urandom % 6 == 0) begin
                wr_en  = 1'b1;
                wr_sel = 2'($urandom % 4);
                case (wr_sel)
                    2'd0:    wr_data = 64'($urandom % 2);
                    2'd1:    wr_data = m_time + 64'($urandom_range(0, 30));
                    2'd2:    wr_data = ($urandom % 4 == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16)
                                                           : 64'($urandom_range(0, 100));
                    default: wr_data = {$urandom, $urandom};
                endcase
            end
            advance();
        end

        done = 1'b1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-003 ext_irq  in  1  level machine-external interrupt line (MEIP source).
REQ-004 mie_mask  in  64  CSR mie; only bits 3 (MSIE), 7 (MTIE), 11 (MEIE) used.
REQ-005 mstatus_mie  in  1  mstatus[3] global machine interrupt enable.
REQ-006 wr_en  in  1  register write strobe, one cycle.
REQ-007 wr_sel  in  2  write target: 0=msip, 1=mtimecmp, 2=mtime, 3=ignored.
REQ-008 wr_data  in  64  write data; msip uses bit 0 only.
REQ-009 trap_taken  in  1  trap-entry pulse from trap handler.
REQ-010 trap_done  in  1  mret-completion pulse from trap handler.
REQ-011 irq_en  out  1  interrupt request, one-cycle pulse.
REQ-012 irq_code  out  4  cause code of requested interrupt (3, 7 or 11).
REQ-013 irq_val  out  64  trap value; always 0.
REQ-014 mip_out  out  64  pending view: bit3=MSIP, bit7=MTIP, bit11=MEIP, others 0.
REQ-015 mtime_out  out  64  current mtime.

Function
REQ-016 mtime SHALL increment by 1 every cycle, wrapping 2^64-1 -> 0.
REQ-017 A write to mtime SHALL load wr_data and suppress that cycle's increment.
REQ-018 MTIP SHALL be combinational: mtime >= mtimecmp, 64-bit unsigned.
REQ-019 MSIP SHALL equal register msip; MEIP SHALL equal ext_irq (no latching).
REQ-020 Eligible set SHALL be mip_out & mie_mask, gated by mstatus_mie.
REQ-021 Priority SHALL be fixed: MEI (11) > MSI (3) > MTI (7).
REQ-022 FSM states: IDLE, FIRE, WAIT_ACK, SERVICE.
REQ-023 IDLE -> FIRE when eligible set non-zero; irq_code SHALL register the winner at that edge.
REQ-024 FIRE: irq_en=1 for exactly one cycle; irq_code held stable; always -> WAIT_ACK.
REQ-025 WAIT_ACK: trap_taken=1 -> SERVICE; else -> IDLE (request dropped, re-arbitrated next cycle).
REQ-026 SERVICE: no requests issued; trap_done=1 -> IDLE; new pending sources ignored until exit.
REQ-027 irq_en SHALL be 0 in IDLE, WAIT_ACK, SERVICE.
REQ-028 irq_code SHALL hold its last value outside FIRE.
REQ-029 Source deasserting after FIRE SHALL NOT cancel an acknowledged trap.
REQ-030 trap_done seen outside SERVICE SHALL be ignored.
REQ-031 Register writes SHALL be accepted in every FSM state; effect visible on mip_out the next cycle.
REQ-032 Re-request latency: pending held through trap_done -> irq_en asserts 2 cycles after the trap_done edge.

Reset
REQ-033 While rst=0: mtime=0, mtimecmp=all ones, msip=0, FSM=IDLE, irq_en=0, irq_code=0, irq_val=0.
REQ-034 Reset mid-SERVICE or mid-FIRE SHALL abort to IDLE with no further pulse.
REQ-035 mtimecmp=all ones SHALL give MTIP=0 except when mtime is all ones.

Structure
REQ-036 Shared package SHALL hold cause-code constants (3/7/11), mip bit indices, wr_sel encodings and the FSM state enum.
REQ-037 One sub-module SHALL be instantiated: irq_prio_enc (combinational eligible-set -> winner code plus valid flag).
REQ-038 All remaining logic (timer, registers, FSM) SHALL live in irq_ctrl.

Verification
REQ-039 Timer: write mtimecmp=20 at mtime=10 with MTIE=1, mstatus_mie=1 -> irq_en pulse, irq_code=7, when mtime reaches 20 (+1 cycle FSM).
REQ-040 Priority: ext_irq=1, msip=1 and MTIP all pending, all enabled -> irq_code=11; after trap_done with ext_irq=0 -> next irq_code=3.
REQ-041 No ack: FIRE with trap_taken held 0 -> IDLE, then a fresh irq_en pulse after 2 cycles while source stays pending.
REQ-042 Masking: msip=1, MSIE=1, mstatus_mie=0 -> no irq_en for 50 cycles; set mstatus_mie=1 -> irq_en pulse with irq_code=3.
REQ-043 Wrap and write priority: mtime written 2^64-2 -> reads 2^64-1, then 0; write mtime=5 in the same cycle as an increment -> next read 5.
REQ-044 Reset in SERVICE: assert rst=0 for 1 cycle -> irq_en=0, mtimecmp=all ones, FSM IDLE, irq_code=0.
